// File: rtl/dff_shift_bank.sv
// WIDTH-bit register bank with q/qbar, clock enable, shift/rotate/load/clear/set
// modes and a saturating shift counter that flags a fully shifted word.
module dff_shift_bank #(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0,
    localparam int unsigned        CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               en,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   d,
    input  logic               sin,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qbar,
    output logic               sout,
    output logic [CNT_W-1:0]   shift_cnt,
    output logic               full_shift
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHL  = 3'b001,
        M_SHR  = 3'b010,
        M_ROL  = 3'b011,
        M_ROR  = 3'b100,
        M_LOAD = 3'b101,
        M_CLR  = 3'b110,
        M_SET  = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: a shift past a full word keeps the count at WIDTH
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (en) begin
            case (mode_e'(mode))
                M_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                M_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], sin};
                    cnt_d = cnt_inc;
                end
                M_SHR: begin
                    q_d   = {sin, q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
                M_ROL: begin
                    q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    cnt_d = cnt_inc;
                end
                M_ROR: begin
                    q_d   = {q_q[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
                M_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                M_CLR: begin
                    q_d   = RESET_VAL;
                    cnt_d = '0;
                end
                M_SET: begin
                    q_d   = {WIDTH{1'b1}};
                    cnt_d = '0;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
        full_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // qbar shares the q register so the pair can never disagree
    assign q          = q_q;
    assign qbar       = ~q_q;
    assign shift_cnt  = cnt_q;
    assign full_shift = full_q;
    assign sout       = (mode == M_SHL || mode == M_ROL) ? q_q[WIDTH-1] : q_q[0];

    mode_known_a: assert property (@(posedge clk) disable iff (!clear) en |-> !$isunknown(mode));

endmodule
